// File: rtl/seg7_scan_ctrl_if.sv
// Scan controller bus: digit data and masks in, decoder nibble and anodes out.
// master = digit source / display side, slave = seg7_scan_ctrl.
interface seg7_scan_ctrl_if #(
  parameter int N_DIG = 6
);
  logic [4*N_DIG-1:0] iDIGITS;
  logic [N_DIG-1:0]   iBLANK;
  logic [N_DIG-1:0]   iBLINK;
  logic [3:0]         oDIG;
  logic [N_DIG-1:0]   oAN;
  logic               oFRAME;
  logic               oBLINK_PH;

  modport master (
    output iDIGITS, iBLANK, iBLINK,
    input  oDIG, oAN, oFRAME, oBLINK_PH
  );

  modport slave (
    input  iDIGITS, iBLANK, iBLINK,
    output oDIG, oAN, oFRAME, oBLINK_PH
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 7-seg multiplexed scan: per-digit blank/blink, ghost gap, frame snapshot.
// Ports: iCLK, iRST (async high), bus (slave: digits/masks in, dig/an out).
module seg7_scan_ctrl #(
  parameter int N_DIG        = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input logic            iCLK,
  input logic            iRST,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIG);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int ON_CYC = SCAN_DIV - BLANK_CYC;

  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] O_LAST = CW'(ON_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIG - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {
    S_BLANK,
    S_ON
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [4*N_DIG-1:0] snap, snap_n;
  logic [FW-1:0]      fcnt, fcnt_n;
  logic               bph, bph_n;
  logic               start;
  logic [N_DIG-1:0]   an, an_n;
  logic [3:0]         dig, dig_n;
  logic               frame;
  logic               load, fend, dark;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    load    = 1'b0;
    fend    = 1'b0;
    // first edge after reset is the BLANK entry of slot 0
    if (start) begin
      state_n = S_BLANK;
      cnt_n   = '0;
      idx_n   = '0;
      load    = 1'b1;
    end else begin
      unique case (state)
        S_BLANK: begin
          if (cnt == B_LAST) begin
            state_n = S_ON;
            cnt_n   = '0;
          end
        end
        S_ON: begin
          if (cnt == O_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            if (idx == I_LAST) begin
              idx_n = '0;
              fend  = 1'b1;
              load  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: state_n = S_BLANK;
      endcase
    end

    fcnt_n = fcnt;
    bph_n  = bph;
    if (fend) begin
      if (fcnt == F_LAST) begin
        fcnt_n = '0;
        bph_n  = ~bph;
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end

    snap_n = load ? bus.iDIGITS : snap;
    dig_n  = snap_n[4*int'(idx_n) +: 4];

    // masks are live; phase is the one valid after this edge
    dark = bus.iBLANK[idx_n] |
           (bus.iBLINK[idx_n] & bph_n);
    an_n = '1;
    if (state_n == S_ON && !dark)
      an_n = ~(N_DIG'(1) << idx_n);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= S_BLANK;
      cnt   <= '0;
      idx   <= '0;
      snap  <= '0;
      fcnt  <= '0;
      bph   <= 1'b0;
      start <= 1'b1;
      an    <= '1;
      dig   <= '0;
      frame <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      snap  <= snap_n;
      fcnt  <= fcnt_n;
      bph   <= bph_n;
      start <= 1'b0;
      an    <= an_n;
      dig   <= dig_n;
      frame <= fend;
    end
  end

  assign bus.oAN       = an;
  assign bus.oDIG      = dig;
  assign bus.oFRAME    = frame;
  assign bus.oBLINK_PH = bph;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (N_DIG=4, SCAN_DIV=8, BLANK_CYC=2).
// Expected values come from the slot/frame timing worked out by hand.
module tb_seg7_scan_ctrl;
  logic clk;
  logic rst;
  int   vec;
  int   fails;
  int   cyc;

  seg7_scan_ctrl_if #(.N_DIG(4)) bus ();

  seg7_scan_ctrl #(
    .N_DIG(4),
    .SCAN_DIV(8),
    .BLANK_CYC(2),
    .BLINK_FRAMES(2)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slot = 8 cycles (2 dark + 6 lit), frame = 32, blink half = 64
  function automatic logic [3:0] exp_an(
    int c, logic [3:0] bl, logic [3:0] bk);
    int   s;
    logic ph;
    s  = (c / 8) % 4;
    ph = ((c / 64) % 2) == 1;
    if (c % 8 < 2) return 4'hF;
    if (bl[s] || (bk[s] && ph)) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [3:0] exp_dig(
    int c, logic [15:0] d);
    return d[((c / 8) % 4) * 4 +: 4];
  endfunction

  function automatic logic exp_fr(int c);
    return (c % 32 == 0) && (c != 0);
  endfunction

  function automatic logic exp_ph(int c);
    return ((c / 64) % 2) == 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.iDIGITS = 16'h1234;
    bus.iBLANK = 4'b0000;
    bus.iBLINK = 4'b0000;
    repeat (3) @(negedge clk);
    vec++;
    if (bus.oAN !== 4'hF) begin
      fails++;
      $display("FAIL reset_an got %b want 1111", bus.oAN);
    end
    vec++;
    if (bus.oDIG !== 4'h0) begin
      fails++;
      $display("FAIL reset_dig got %h want 0", bus.oDIG);
    end
    vec++;
    if (bus.oFRAME !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame got %b want 0", bus.oFRAME);
    end
    vec++;
    if (bus.oBLINK_PH !== 1'b0) begin
      fails++;
      $display("FAIL reset_ph got %b want 0", bus.oBLINK_PH);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_basic_scan();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      vec++;
      if (bus.oAN !== exp_an(cyc, 4'h0, 4'h0)) begin
        fails++;
        $display("FAIL basic_an cyc=%0d got %b want %b",
          cyc, bus.oAN, exp_an(cyc, 4'h0, 4'h0));
      end
      vec++;
      if (bus.oDIG !== exp_dig(cyc, 16'h1234)) begin
        fails++;
        $display("FAIL basic_dig cyc=%0d got %h want %h",
          cyc, bus.oDIG, exp_dig(cyc, 16'h1234));
      end
      vec++;
      if (bus.oFRAME !== exp_fr(cyc)) begin
        fails++;
        $display("FAIL basic_frame cyc=%0d got %b want %b",
          cyc, bus.oFRAME, exp_fr(cyc));
      end
      cyc++;
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      d = (cyc < 96) ? 16'h1234 : 16'h5678;
      vec++;
      if (bus.oDIG !== exp_dig(cyc, d)) begin
        fails++;
        $display("FAIL tear_dig cyc=%0d got %h want %h",
          cyc, bus.oDIG, exp_dig(cyc, d));
      end
      vec++;
      if (bus.oAN !== exp_an(cyc, 4'h0, 4'h0)) begin
        fails++;
        $display("FAIL tear_an cyc=%0d got %b want %b",
          cyc, bus.oAN, exp_an(cyc, 4'h0, 4'h0));
      end
      if (cyc == 82) bus.iDIGITS = 16'h5678;
      cyc++;
    end
  endtask

  task automatic test_blank_blink();
    bus.iBLANK = 4'b0001;
    bus.iBLINK = 4'b0100;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      vec++;
      if (bus.oAN !== exp_an(cyc, 4'b0001, 4'b0100)) begin
        fails++;
        $display("FAIL blink_an cyc=%0d got %b want %b",
          cyc, bus.oAN, exp_an(cyc, 4'b0001, 4'b0100));
      end
      vec++;
      if (bus.oBLINK_PH !== exp_ph(cyc)) begin
        fails++;
        $display("FAIL blink_ph cyc=%0d got %b want %b",
          cyc, bus.oBLINK_PH, exp_ph(cyc));
      end
      vec++;
      if (bus.oFRAME !== exp_fr(cyc)) begin
        fails++;
        $display("FAIL blink_frame cyc=%0d got %b want %b",
          cyc, bus.oFRAME, exp_fr(cyc));
      end
      vec++;
      if (bus.oDIG !== exp_dig(cyc, 16'h5678)) begin
        fails++;
        $display("FAIL blink_dig cyc=%0d got %h want %h",
          cyc, bus.oDIG, exp_dig(cyc, 16'h5678));
      end
      cyc++;
    end
  endtask

  task automatic test_mid_reset();
    bus.iBLANK = 4'b0000;
    bus.iBLINK = 4'b0000;
    while (cyc <= 339) begin
      @(negedge clk);
      vec++;
      if (bus.oAN !== exp_an(cyc, 4'h0, 4'h0)) begin
        fails++;
        $display("FAIL pre_rst_an cyc=%0d got %b want %b",
          cyc, bus.oAN, exp_an(cyc, 4'h0, 4'h0));
      end
      vec++;
      if (bus.oBLINK_PH !== exp_ph(cyc)) begin
        fails++;
        $display("FAIL pre_rst_ph cyc=%0d got %b want %b",
          cyc, bus.oBLINK_PH, exp_ph(cyc));
      end
      cyc++;
    end
    vec++;
    if (bus.oAN !== 4'b1011) begin
      fails++;
      $display("FAIL pre_rst_slot2 got %b want 1011", bus.oAN);
    end
    #2 rst = 1'b1;
    bus.iDIGITS = 16'h9ABC;
    #1;
    vec++;
    if (bus.oAN !== 4'hF) begin
      fails++;
      $display("FAIL async_rst_an got %b want 1111", bus.oAN);
    end
    @(negedge clk);
    vec++;
    if (bus.oBLINK_PH !== 1'b0) begin
      fails++;
      $display("FAIL rst_ph got %b want 0", bus.oBLINK_PH);
    end
    vec++;
    if (bus.oDIG !== 4'h0) begin
      fails++;
      $display("FAIL rst_dig got %h want 0", bus.oDIG);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      vec++;
      if (bus.oAN !== exp_an(cyc, 4'h0, 4'h0)) begin
        fails++;
        $display("FAIL post_rst_an cyc=%0d got %b want %b",
          cyc, bus.oAN, exp_an(cyc, 4'h0, 4'h0));
      end
      vec++;
      if (bus.oDIG !== exp_dig(cyc, 16'h9ABC)) begin
        fails++;
        $display("FAIL post_rst_dig cyc=%0d got %h want %h",
          cyc, bus.oDIG, exp_dig(cyc, 16'h9ABC));
      end
      vec++;
      if (bus.oBLINK_PH !== 1'b0) begin
        fails++;
        $display("FAIL post_rst_ph cyc=%0d got %b want 0",
          cyc, bus.oBLINK_PH);
      end
      cyc++;
    end
  endtask

  task automatic test_one_hot();
    int zeros;
    for (int f = 0; f < 1000; f++) begin
      bus.iBLANK  = 4'($urandom);
      bus.iBLINK  = 4'($urandom);
      bus.iDIGITS = 16'($urandom);
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        zeros = $countones(~bus.oAN);
        vec++;
        if (zeros > 1) begin
          fails++;
          $display("FAIL one_hot frame=%0d got %b want <=1 low",
            f, bus.oAN);
        end
      end
    end
  endtask

  initial begin
    vec   = 0;
    fails = 0;
    cyc   = 0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_blank_blink();
    test_mid_reset();
    test_one_hot();
    $display("== %0d vectors applied, %0d miscompares ==",
      vec, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the clock's common-anode 7-segment display bank. It owns the single shared BCD-to-segment decoder and sequences it across `N_DIG` digit positions. For each position it presents one nibble to the decoder and drives the matching active-low anode. Per-digit blanking, per-digit blinking (time-setting cursor) and an inter-digit ghost-suppression gap are applied. Digit data is snapshotted once per frame so a counter update mid-scan never tears the displayed time.

## Interface
Parameters:
- `N_DIG`, 6, number of multiplexed digit positions (2..8).
- `SCAN_DIV`, 50000, clock cycles per digit slot; must be > `BLANK_CYC`.
- `BLANK_CYC`, 16, cycles at the start of each slot with all anodes off; must be ≥ 1.
- `BLINK_FRAMES`, 64, frames per blink half-period; must be ≥ 1.

Ports (clock and reset first):
- `iCLK`  input  1  system clock; all state on rising edge.
- `iRST`  input  1  **asynchronous, active-high reset**.
- `iDIGITS`  input  4*N_DIG  packed nibbles; digit k = `iDIGITS[4k+3:4k]`, digit 0 rightmost.
- `iBLANK`  input  N_DIG  1 = digit k permanently dark.
- `iBLINK`  input  N_DIG  1 = digit k dark during blink-off phase.
- `oDIG`  output  4  nibble to the shared segment decoder.
- `oAN`  output  N_DIG  anode enables, active-low, at most one bit low.
- `oFRAME`  output  1  one-cycle pulse at end of each full scan frame.
- `oBLINK_PH`  output  1  current blink phase (1 = blinked digits dark).

## Operation
- Registers: slot index `idx` (0..N_DIG-1), slot counter `cnt` (width clog2(SCAN_DIV)), state, snapshot `snap` (4*N_DIG bits), frame counter `fcnt` (clog2(BLINK_FRAMES) bits), blink phase.
- FSM with two states:
  - BLANK: `oAN` all ones. Lasts `BLANK_CYC` cycles (`cnt` 0..BLANK_CYC-1). On the last cycle, go to ON with `cnt`=0.
  - ON: `oAN[idx]`=0 unless the digit is dark. Lasts ON_CYC = SCAN_DIV−BLANK_CYC cycles. On the last cycle, go to BLANK with `cnt`=0 and `idx` incremented.
- `idx` wraps from N_DIG−1 to 0.
- Digit k is dark when `iBLANK[k]`, or when `iBLINK[k]` and blink phase = 1. A dark digit keeps all anodes high for its whole ON period. Slot timing is unchanged, so brightness of the other digits is unaffected.
- Snapshot: `snap` ← `iDIGITS` on the edge that enters BLANK with `idx`=0. This includes the first BLANK after reset release. `iDIGITS` changes at any other time are invisible until the next frame. `iBLANK`/`iBLINK` are sampled live.
- `oDIG` = `snap` nibble of `idx`. It is stable for the whole slot, including BLANK, so the decoder settles before the anode turns on.
- Frame end is the ON→BLANK transition with `idx`=N_DIG−1:
  - `oFRAME`=1 for that one cycle.
  - `fcnt` increments. When it wraps at BLINK_FRAMES−1, the blink phase toggles.
- Reset state (asynchronous):
  - State BLANK, `idx`=0, `cnt`=0, `snap`=0, `fcnt`=0, blink phase 0.
  - `oAN` all ones, `oDIG`=0, `oFRAME`=0, `oBLINK_PH`=0.
- Reset asserted mid-slot forces all anodes off immediately (asynchronously). After release, the scan restarts at digit 0 with a fresh snapshot.

## Timing
- All outputs are registers, updated on the same edge as the FSM state. `oAN[idx]` is low for exactly ON_CYC consecutive cycles per slot.
- Slot period = SCAN_DIV cycles. Frame period = N_DIG*SCAN_DIV cycles. Blink half-period = BLINK_FRAMES frames.
- Default per-digit refresh at 50 MHz: 50 MHz / 300000 ≈ 167 Hz.
- First reset-release edge: enter BLANK idx 0 and load `snap`. `oDIG` reflects `iDIGITS[3:0]` from the next cycle.
- `oFRAME` pulse and the blink phase toggle coincide on the frame-end edge. `oBLINK_PH` changes exactly there.
- Gaps between anodes: never two anodes low in the same cycle. Between any two lit slots there are ≥ `BLANK_CYC` cycles with all anodes high.
- Simultaneous change of `iDIGITS` with the snapshot edge: the value present at that edge is captured.

## Test plan
Test parameters: N_DIG=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.

- **Reset/idle.** Hold `iRST`, then release. Required: `oAN`=4'b1111 and `oDIG`=0 during reset. The first lit slot is `oAN`=4'b1110 for 6 cycles, starting 2 cycles after BLANK entry.
- **Basic scan.** `iDIGITS`=16'h1234, masks 0. Required:
  - `oAN` sequence 1110/1101/1011/0111, each low for 6 cycles with 2-cycle all-high gaps.
  - `oDIG` = 4, 3, 2, 1 per slot.
  - `oFRAME` pulses every 32 cycles.
- **Tear-free update.** Change `iDIGITS` to 16'h5678 during slot 2. Required: slots 2 and 3 still show 2 and 1. The next frame shows 8, 7, 6, 5.
- **Blank and blink.** `iBLANK`=4'b0001, `iBLINK`=4'b0100. Required:
  - Digit 0 is never lit.
  - Digit 2 is lit for 2 frames, dark for 2 frames, repeating.
  - `oBLINK_PH` toggles every 64 cycles, coincident with `oFRAME`.
  - Digits 1 and 3 are lit every frame.
- **Mid-slot reset.** Assert `iRST` asynchronously while `oAN`=4'b1011. Required: `oAN`=4'b1111 before the next clock edge. After release, the scan restarts at digit 0 with a new snapshot and `oBLINK_PH`=0.
- **One-hot check.** Over 1000 random frames with random masks, assert `oAN` never has more than one zero bit.
